// File: rtl/accum_pkg.sv
// accum_pkg: shared widths, table entry layout, scheduler states and ring-pointer helper
package accum_pkg;
  localparam int KEY_W = 32;
  localparam int CNT_W = 32;
  localparam int ADDR_W = 32;
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] cnt;
  } entry_t;
  typedef enum logic [1:0] {ACCUM, QUIESCE, DRAIN, DONE} sched_state_e;
  function automatic int wrap_inc(input int p, input int n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/accum_array_sched_if.sv
// accum_array_sched_if: requester lanes, accum_array port and result stream of the scheduler
interface accum_array_sched_if #(parameter int N_REQ = 4);
  import accum_pkg::*;
  logic [N_REQ-1:0] in_valid;
  logic [N_REQ-1:0] in_ready;
  logic [N_REQ*ADDR_W-1:0] in_addr;
  logic [N_REQ*KEY_W-1:0] in_key;
  logic [N_REQ*CNT_W-1:0] in_cnt;
  logic flush;
  logic busy;
  logic done;
  logic err_drop;
  logic [ADDR_W-1:0] mem_addr;
  logic [KEY_W+CNT_W-1:0] mem_din;
  logic mem_we;
  logic [KEY_W+CNT_W-1:0] mem_q;
  logic out_valid;
  logic out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [KEY_W+CNT_W-1:0] out_data;
  modport slave (
    input in_valid, in_addr, in_key, in_cnt, flush, mem_q, out_ready,
    output in_ready, busy, done, err_drop, mem_addr, mem_din, mem_we, out_valid, out_addr, out_data
  );
  modport master (
    output in_valid, in_addr, in_key, in_cnt, flush, mem_q, out_ready,
    input in_ready, busy, done, err_drop, mem_addr, mem_din, mem_we, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/accum_array_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from the lane after the last granted one
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  always_comb begin
    grant = '0;
    idx = ptr_q;
    for (int i = N; i >= 1; i--) begin
      if (en && req[(int'(ptr_q) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr_q) + i) % N] = 1'b1;
        idx = IW'((int'(ptr_q) + i) % N);
      end
    end
    ptr_d = (|grant) ? idx : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
endmodule

// File: rtl/accum_array_sched.sv
// accum_array_sched: round-robin accumulate-write scheduler with flush/drain sweep; ACCUM_SCHED_SKIP_ZERO_EN drops zero-count results
module accum_array_sched
  import accum_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = 16,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 2
) (
  input logic clk,
  input logic reset,
  accum_array_sched_if.slave bus
);
  localparam int FD = RD_LAT + 1;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam int RW = $clog2(DEPTH) + 1;
  localparam int QW = $clog2(WR_LAT + 2);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  sched_state_e state_q, state_d;
  logic [QW-1:0] qc_q, qc_d;
  logic [RW-1:0] rd_ptr_q, rd_ptr_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [KEY_W+CNT_W-1:0] mem_din_q, mem_din_d;
  logic err_q, err_d;
  logic [RD_LAT:0] vld_q, vld_d;
  logic [ADDR_W-1:0] paddr_q [RD_LAT+1];
  logic [ADDR_W-1:0] paddr_d [RD_LAT+1];
  entry_t fifo_q [FD];
  entry_t fifo_d [FD];
  logic [ADDR_W-1:0] faddr_q [FD];
  logic [ADDR_W-1:0] faddr_d [FD];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0] gidx;
  logic accept, req_ok, issue, push, pop;
  logic [ADDR_W-1:0] req_addr;
  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .clk(clk),
    .reset(reset),
    .en(state_q == ACCUM && !reset),
    .req(bus.in_valid),
    .grant(grant),
    .idx(gidx)
  );
  assign accept = |grant;
  assign req_addr = bus.in_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign req_ok = req_addr < ADDR_W'(DEPTH);
  assign issue = state_q == DRAIN && rd_ptr_q != RW'(DEPTH) && ($countones(vld_q) + int'(cnt_q) < FD);
`ifdef ACCUM_SCHED_SKIP_ZERO_EN
  assign push = vld_q[RD_LAT] && (bus.mem_q[CNT_W-1:0] != '0);
`else
  assign push = vld_q[RD_LAT];
`endif
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    state_d = state_q;
    qc_d = qc_q;
    rd_ptr_d = issue ? rd_ptr_q + RW'(1) : rd_ptr_q;
    mem_we_d = accept && req_ok;
    mem_addr_d = accept ? req_addr : issue ? ADDR_W'(rd_ptr_q) : mem_addr_q;
    mem_din_d = accept ? {bus.in_key[int'(gidx)*KEY_W +: KEY_W], bus.in_cnt[int'(gidx)*CNT_W +: CNT_W]} : mem_din_q;
    err_d = err_q || (accept && !req_ok);
    vld_d = {vld_q[RD_LAT-1:0], issue};
    paddr_d[0] = ADDR_W'(rd_ptr_q);
    for (int k = 1; k <= RD_LAT; k++) paddr_d[k] = paddr_q[k-1];
    fifo_d = fifo_q;
    faddr_d = faddr_q;
    if (push) begin
      fifo_d[wp_q] = entry_t'(bus.mem_q);
      faddr_d[wp_q] = paddr_q[RD_LAT];
    end
    wp_d = push ? PW'(wrap_inc(int'(wp_q), FD)) : wp_q;
    rp_d = pop ? PW'(wrap_inc(int'(rp_q), FD)) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    case (state_q)
      ACCUM: begin
        state_d = bus.flush ? QUIESCE : ACCUM;
        qc_d = '0;
      end
      QUIESCE: begin
        qc_d = qc_q + QW'(1);
        if (qc_q == QW'(WR_LAT)) begin
          state_d = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: state_d = (rd_ptr_q == RW'(DEPTH) && vld_q == '0 && cnt_q == '0) ? DONE : DRAIN;
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      qc_q <= '0;
      rd_ptr_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      paddr_q <= '{default: '0};
      fifo_q <= '{default: '0};
      faddr_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      qc_q <= qc_d;
      rd_ptr_q <= rd_ptr_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      err_q <= err_d;
      vld_q <= vld_d;
      paddr_q <= paddr_d;
      fifo_q <= fifo_d;
      faddr_q <= faddr_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.in_ready = grant;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din = mem_din_q;
  assign bus.err_drop = err_q;
  assign bus.busy = state_q == QUIESCE || state_q == DRAIN;
  assign bus.done = state_q == DONE;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data = fifo_q[rp_q];
  assign bus.out_addr = faddr_q[rp_q];
endmodule

// File: tb/tb_accum_array_sched.sv
// tb_accum_array_sched: directed checks of grant rotation, accumulate writes, drain order, back-pressure, flush and reset
module tb_accum_array_sched;
  import accum_pkg::*;
  localparam int N_REQ = 4;
  localparam int DEPTH = 16;
  localparam int RD_LAT = 1;
  localparam int WR_LAT = 2;
`ifdef ACCUM_SCHED_SKIP_ZERO_EN
  localparam int N_RES = 4;
  localparam int S4_N = 5;
  localparam int S4_I = 4;
`else
  localparam int N_RES = DEPTH;
  localparam int S4_N = DEPTH;
  localparam int S4_I = 5;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_grant = 0;
  int unstable = 0;
  int d0;
  logic prev_stall = 1'b0;
  logic [95:0] prev_out = '0;
  logic [63:0] mem [DEPTH];
  logic [95:0] res_q [$];
  accum_array_sched_if #(.N_REQ(N_REQ)) bus();
  accum_array_sched #(.N_REQ(N_REQ), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.mem_we && bus.mem_addr < 32'(DEPTH)) begin
      mem[bus.mem_addr[3:0]] <= {bus.mem_din[63:32], mem[bus.mem_addr[3:0]][31:0] + bus.mem_din[31:0]};
    end
    bus.mem_q <= (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[3:0]] : 64'd0;
  end
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) res_q.push_back({bus.out_addr, bus.out_data});
    if (bus.done) done_cnt++;
    if ((bus.busy || bus.done) && bus.in_ready != '0) busy_grant++;
    if (prev_stall && !reset && (!bus.out_valid || {bus.out_addr, bus.out_data} != prev_out)) unstable++;
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_out = {bus.out_addr, bus.out_data};
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] k, input logic [31:0] c);
    bus.in_addr[l*32 +: 32] = a;
    bus.in_key[l*32 +: 32] = k;
    bus.in_cnt[l*32 +: 32] = c;
  endtask
  function automatic logic [31:0] key_of(input int a);
    return a == 0 ? 32'hDEADBEEF : a == 1 ? 32'hABADCAFE : a == 2 ? 32'hFEFEFEFE : 32'h34343434;
  endfunction
  function automatic logic [63:0] exp_data(input int a);
    return a == 0 ? {32'hDEADBEEF, 32'd7} : a == 1 ? {32'hABADCAFE, 32'd3} :
           a == 2 ? {32'hFEFEFEFE, 32'd1} : a == 3 ? {32'h34343434, 32'd2} : 64'd0;
  endfunction
  function automatic int addr_of(input int i);
    return i < 7 ? 0 : i < 10 ? 1 : i < 11 ? 2 : 3;
  endfunction
  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      tick();
      n++;
    end
    check(tag, 96'(bus.done), 96'(1));
  endtask
  task automatic check_results(input string tag);
    check({tag, "_count"}, 96'(res_q.size()), 96'(N_RES));
    for (int i = 0; i < N_RES && i < res_q.size(); i++) check(tag, res_q[i], {32'(i), exp_data(i)});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = '0;
    bus.in_addr = '0;
    bus.in_key = '0;
    bus.in_cnt = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 96'(bus.in_ready), 96'(0));
    check("rst_mem_we", 96'(bus.mem_we), 96'(0));
    check("rst_mem_addr", 96'(bus.mem_addr), 96'(0));
    check("rst_mem_din", 96'(bus.mem_din), 96'(0));
    check("rst_out_valid", 96'(bus.out_valid), 96'(0));
    check("rst_busy", 96'(bus.busy), 96'(0));
    check("rst_done", 96'(bus.done), 96'(0));
    check("rst_err_drop", 96'(bus.err_drop), 96'(0));
    reset = 1'b0;
    mem_clr = 1'b0;
    set_lane(0, 0, 32'hDEADBEEF, 1);
    set_lane(1, 0, 32'hDEADBEEF, 1);
    bus.in_valid = 4'b0011;
    #1;
    check("s1_grant_a", 96'(bus.in_ready), 96'(4'b0010));
    tick();
    check("s1_grant_b", 96'(bus.in_ready), 96'(4'b0001));
    check("s1_we_a", 96'(bus.mem_we), 96'(1));
    check("s1_din", 96'(bus.mem_din), 96'({32'hDEADBEEF, 32'd1}));
    tick();
    check("s1_grant_c", 96'(bus.in_ready), 96'(4'b0010));
    check("s1_we_b", 96'(bus.mem_we), 96'(1));
    tick();
    check("s1_grant_d", 96'(bus.in_ready), 96'(4'b0001));
    bus.in_valid = '0;
    tick();
    check("s1_we_idle", 96'(bus.mem_we), 96'(0));
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 13; i++) begin
      set_lane(0, 32'(addr_of(i)), key_of(addr_of(i)), 1);
      tick();
    end
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    d0 = done_cnt;
    tick();
    bus.flush = 1'b0;
    check("s2_busy", 96'(bus.busy), 96'(1));
    wait_done("s2_done", 300);
    tick();
    check("s2_done_once", 96'(done_cnt - d0), 96'(1));
    check("s2_busy_after", 96'(bus.busy), 96'(0));
    check_results("s2_res");
    res_q.delete();
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (20) tick();
    check("s3_last_read_addr", 96'(bus.mem_addr), 96'(1));
    check("s3_stall_valid", 96'(bus.out_valid), 96'(1));
    check("s3_stall_addr", 96'(bus.out_addr), 96'(0));
    check("s3_stall_data", 96'(bus.out_data), 96'({32'hDEADBEEF, 32'd7}));
    check("s3_none_yet", 96'(res_q.size()), 96'(0));
    for (int n = 0; n < 400 && !bus.done; n++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    check("s3_done", 96'(bus.done), 96'(1));
    tick();
    check_results("s3_res");
    check("s3_stable", 96'(unstable), 96'(0));
    res_q.delete();
    bus.out_ready = 1'b1;
    set_lane(2, 5, 32'h55555555, 9);
    bus.in_valid = 4'b0100;
    bus.flush = 1'b1;
    #1;
    check("s4_grant_flush", 96'(bus.in_ready), 96'(4'b0100));
    tick();
    bus.flush = 1'b0;
    check("s4_ready_off", 96'(bus.in_ready), 96'(0));
    check("s4_busy", 96'(bus.busy), 96'(1));
    wait_done("s4_done", 300);
    tick();
    check("s4_regrant", 96'(bus.in_ready), 96'(4'b0100));
    tick();
    bus.in_valid = '0;
    check("s4_we", 96'(bus.mem_we), 96'(1));
    check("s4_addr", 96'(bus.mem_addr), 96'(5));
    check("s4_no_grant_busy", 96'(busy_grant), 96'(0));
    check("s4_count", 96'(res_q.size()), 96'(S4_N));
    if (res_q.size() > S4_I) check("s4_entry5", res_q[S4_I], {32'd5, 32'h55555555, 32'd9});
    res_q.delete();
    check("s5_err_clear", 96'(bus.err_drop), 96'(0));
    set_lane(1, 32'(DEPTH + 3), 32'h11111111, 1);
    bus.in_valid = 4'b0010;
    #1;
    check("s5_grant", 96'(bus.in_ready), 96'(4'b0010));
    tick();
    bus.in_valid = '0;
    check("s5_no_we", 96'(bus.mem_we), 96'(0));
    check("s5_err_set", 96'(bus.err_drop), 96'(1));
    tick();
    check("s5_err_sticky", 96'(bus.err_drop), 96'(1));
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (10) tick();
    check("s5_busy_drain", 96'(bus.busy), 96'(1));
    check("s5_valid_drain", 96'(bus.out_valid), 96'(1));
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    check("s5_rst_valid", 96'(bus.out_valid), 96'(0));
    check("s5_rst_busy", 96'(bus.busy), 96'(0));
    check("s5_rst_err", 96'(bus.err_drop), 96'(0));
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (30) tick();
    check("s5_no_done", 96'(done_cnt - d0), 96'(0));
    check("s5_idle_valid", 96'(bus.out_valid), 96'(0));
    check("s5_idle_busy", 96'(bus.busy), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
